bsg_chan_loopback_remap: RTL and testbench
==========================================

BSG_CHAN_LOOPBACK_REMAP -- requirements
Module: bsg_chan_loopback_remap

Interface
REQ-001 SHALL have parameter channels_p, default 4, number of IO channels (2..16).
REQ-002 SHALL have parameter width_p, default 8, data bits per channel.
REQ-003 SHALL have parameter els_p, default 4, per-output FIFO depth (power of 2, >=2).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n_i  input  1  synchronous active-low reset.
REQ-006 SHALL have port v_i  input  channels_p  per-input-channel valid.
REQ-007 SHALL have port data_i  input  channels_p*width_p  input data; channel c at bits [c*width_p +: width_p].
REQ-008 SHALL have port ready_o  output  channels_p  per-input ready; transfer when v_i[c] & ready_o[c].
REQ-009 SHALL have port v_o  output  channels_p  per-output valid; high when that output FIFO is non-empty.
REQ-010 SHALL have port data_o  output  channels_p*width_p  output FIFO head data, same packing as data_i.
REQ-011 SHALL have port yumi_i  input  channels_p  consumer dequeue; legal only when v_o[d]=1.
REQ-012 SHALL have port cfg_v_i  input  1  remap-table write strobe.
REQ-013 SHALL have port cfg_dst_i  input  clog2(channels_p)  output channel being written.
REQ-014 SHALL have port cfg_src_i  input  clog2(channels_p)  source input channel for cfg_dst_i.
REQ-015 SHALL have port pat_en_i  input  1  1 selects pattern-generator mode; 0 selects remap mode.
REQ-016 SHALL have port err_cnt_o  output  channels_p*16  per-input mismatch counters.

Function
REQ-017 SHALL hold map[d] per output d; output d sources input map[d].
REQ-018 SHALL write map[cfg_dst_i]=cfg_src_i at the edge where cfg_v_i=1; enqueues in that same cycle use the old map.
REQ-019 SHALL NOT change data already in FIFOs on a map write.
REQ-020 Remap mode: SHALL drive ready_o[s] = AND of not-full over all d with map[d]==s; 1 if no d maps s (data discarded).
REQ-021 Remap mode: on v_i[s]&ready_o[s], SHALL enqueue data_i[s] into every FIFO d with map[d]==s (fan-out, atomic).
REQ-022 SHALL assert v_o[d] one cycle after the enqueue into an empty FIFO (1-cycle latency); data_o[d] = oldest entry.
REQ-023 SHALL handle simultaneous enqueue and dequeue on a non-empty FIFO with unchanged occupancy; full FIFO blocks enqueue even if yumi_i is high that cycle.
REQ-024 SHALL wrap FIFO read/write pointers modulo els_p with no bubble; all els_p entries usable.
REQ-025 Pattern mode: SHALL enqueue pattern counter pc[d] into FIFO d whenever not full, then pc[d]=pc[d]+1 mod 2^width_p.
REQ-026 Pattern mode: inputs SHALL NOT enqueue into FIFOs; pc[d] SHALL hold while FIFO d is full.
REQ-027 Mode change SHALL take effect at the next edge; FIFO contents are preserved and drained in order.

Reset
REQ-028 While reset_n_i=0 at an edge: FIFOs empty, map[d]=d, pc[d]=d, err counters and expected counters 0.
REQ-029 During and after reset until the first enqueue: v_o=0, ready_o=0 during reset, data_o=0 when empty.
REQ-030 Reset mid-transfer SHALL discard all FIFO contents; no partial output.

Configuration
REQ-031 Macro BSG_CHAN_LOOPBACK_CHECK_EN defined: in pattern mode ready_o=all ones; each accepted data_i[s] compared with exp[s]; mismatch increments err_cnt[s] (16-bit, saturating at 0xFFFF); exp[s] then set to data_i[s]+1 either way.
REQ-032 Macro undefined: err_cnt_o tied to 0; ready_o=0 in pattern mode; no checker state.

Verification
REQ-033 Reset, identity map, v_i[2]=1 data 0x5A -> next cycle v_o[2]=1, data_o[2]=0x5A; other v_o=0.
REQ-034 Write map[1]=3 and map[0]=3, send 0x11 on input 3 -> outputs 0 and 1 both present 0x11; ready_o[3]=0 if either FIFO full.
REQ-035 Identity map, yumi_i=0, push 5 words on channel 0 with els_p=4 -> 4 accepted, ready_o[0]=0 on 5th; one yumi -> 5th accepted next cycle.
REQ-036 pat_en_i=1, yumi_i all ones -> output 1 streams 0x01,0x02,...,0xFF,0x00 continuously.
REQ-037 CHECK_EN, pattern mode, input 0 sends 0,1,2,7,8 -> err_cnt[0]=1 after the sequence.
REQ-038 Assert reset_n_i=0 with 3 words queued -> v_o=0 next cycle, map back to identity.

Source files
------------

// File: rtl/bsg_chan_loopback_remap.sv
// bsg_chan_loopback_remap
//   Multi-channel loopback with a runtime-programmable output->input remap
//   table. Each output owns a small FIFO. In remap mode each input fans out
//   atomically to every output that maps to it. In pattern mode each output
//   FIFO is fed from its own free-running counter.
//   Optional input-stream checker: define BSG_CHAN_LOOPBACK_CHECK_EN to count
//   per-input sequence errors while in pattern mode.
module bsg_chan_loopback_remap #(
  parameter int unsigned channels_p = 4,
  parameter int unsigned width_p    = 8,
  parameter int unsigned els_p      = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [channels_p-1:0]              v_i,
  input  logic [channels_p*width_p-1:0]      data_i,
  output logic [channels_p-1:0]              ready_o,
  output logic [channels_p-1:0]              v_o,
  output logic [channels_p*width_p-1:0]      data_o,
  input  logic [channels_p-1:0]              yumi_i,
  input  logic                               cfg_v_i,
  input  logic [$clog2(channels_p)-1:0]      cfg_dst_i,
  input  logic [$clog2(channels_p)-1:0]      cfg_src_i,
  input  logic                               pat_en_i,
  output logic [channels_p*16-1:0]           err_cnt_o
);

  localparam int unsigned SelW = $clog2(channels_p);
  localparam int unsigned PtrW = $clog2(els_p);
  localparam int unsigned CntW = PtrW + 1;

`ifdef BSG_CHAN_LOOPBACK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic [SelW-1:0]    map_q   [channels_p];
  logic [width_p-1:0] mem_q   [channels_p][els_p];
  logic [PtrW-1:0]    rptr_q  [channels_p];
  logic [PtrW-1:0]    wptr_q  [channels_p];
  logic [CntW-1:0]    cnt_q   [channels_p];
  logic [width_p-1:0] pc_q    [channels_p];

  logic [width_p-1:0]    in_data  [channels_p];
  logic [width_p-1:0]    enq_data [channels_p];
  logic [channels_p-1:0] full;
  logic [channels_p-1:0] empty;
  logic [channels_p-1:0] enq;
  logic [channels_p-1:0] deq;
  logic [channels_p-1:0] ready;

  // Unpack input bus and derive per-FIFO status.
  always_comb begin
    for (int c = 0; c < channels_p; c++) begin
      in_data[c] = data_i[c*width_p +: width_p];
      full[c]    = (cnt_q[c] == CntW'(els_p));
      empty[c]   = (cnt_q[c] == '0);
    end
  end

  // Input ready: in remap mode an input is ready only if every output that
  // sources it has room; an unmapped input is always ready and its data dropped.
  always_comb begin
    ready = '0;
    if (reset_n_i) begin
      if (pat_en_i) begin
        ready = CheckEn ? '1 : '0;
      end else begin
        for (int s = 0; s < channels_p; s++) begin
          ready[s] = 1'b1;
          for (int d = 0; d < channels_p; d++) begin
            if ((map_q[d] == SelW'(s)) && full[d]) ready[s] = 1'b0;
          end
        end
      end
    end
  end

  assign ready_o = ready;

  // Per-output enqueue/dequeue decisions using the current (pre-write) map.
  always_comb begin
    enq = '0;
    deq = '0;
    for (int d = 0; d < channels_p; d++) begin
      enq_data[d] = '0;
      if (pat_en_i) begin
        enq[d]      = ~full[d];
        enq_data[d] = pc_q[d];
      end else begin
        enq[d]      = v_i[map_q[d]] & ready[map_q[d]];
        enq_data[d] = in_data[map_q[d]];
      end
      deq[d] = yumi_i[d] & ~empty[d];
    end
  end

  // Output valid/data; data reads as zero whenever a FIFO is empty.
  always_comb begin
    data_o = '0;
    for (int d = 0; d < channels_p; d++) begin
      v_o[d] = ~empty[d];
      if (!empty[d]) data_o[d*width_p +: width_p] = mem_q[d][rptr_q[d]];
    end
  end

  // FIFO pointers/occupancy, pattern counters and remap table.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int d = 0; d < channels_p; d++) begin
        rptr_q[d] <= '0;
        wptr_q[d] <= '0;
        cnt_q[d]  <= '0;
        map_q[d]  <= SelW'(d);
        pc_q[d]   <= width_p'(d);
      end
    end else begin
      for (int d = 0; d < channels_p; d++) begin
        if (enq[d]) begin
          mem_q[d][wptr_q[d]] <= enq_data[d];
          wptr_q[d]           <= wptr_q[d] + PtrW'(1);
        end
        if (deq[d]) rptr_q[d] <= rptr_q[d] + PtrW'(1);
        if (enq[d] && !deq[d]) begin
          cnt_q[d] <= cnt_q[d] + CntW'(1);
        end else if (!enq[d] && deq[d]) begin
          cnt_q[d] <= cnt_q[d] - CntW'(1);
        end
        if (pat_en_i && enq[d]) pc_q[d] <= pc_q[d] + width_p'(1);
      end
      if (cfg_v_i) map_q[cfg_dst_i] <= cfg_src_i;
    end
  end

`ifdef BSG_CHAN_LOOPBACK_CHECK_EN
  logic [width_p-1:0] exp_q [channels_p];
  logic [15:0]        err_q [channels_p];

  // Sequence checker: each accepted word should be the previous word + 1.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int s = 0; s < channels_p; s++) begin
        exp_q[s] <= '0;
        err_q[s] <= '0;
      end
    end else if (pat_en_i) begin
      for (int s = 0; s < channels_p; s++) begin
        if (v_i[s] && ready[s]) begin
          if ((in_data[s] != exp_q[s]) && (err_q[s] != 16'hFFFF)) begin
            err_q[s] <= err_q[s] + 16'd1;
          end
          exp_q[s] <= in_data[s] + width_p'(1);
        end
      end
    end
  end

  // Pack error counters.
  always_comb begin
    for (int s = 0; s < channels_p; s++) err_cnt_o[s*16 +: 16] = err_q[s];
  end
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_chan_loopback_remap.sv
// Randomized bench for bsg_chan_loopback_remap against a queue-based model.
module tb_bsg_chan_loopback_remap;

  localparam int C = 4;
  localparam int W = 8;
  localparam int E = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [C-1:0]   v_i, ready_o, v_o, yumi_i;
  logic [C*W-1:0] data_i, data_o;
  logic           cfg_v;
  logic [1:0]     cfg_dst, cfg_src;
  logic           pat_en;
  logic [C*16-1:0] err_cnt_o;

  always #5 clk = ~clk;

  bsg_chan_loopback_remap #(.channels_p(C), .width_p(W), .els_p(E)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .data_o   (data_o),
    .yumi_i   (yumi_i),
    .cfg_v_i  (cfg_v),
    .cfg_dst_i(cfg_dst),
    .cfg_src_i(cfg_src),
    .pat_en_i (pat_en),
    .err_cnt_o(err_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] mq [C][$];
  int           mmap [C];
  logic [W-1:0] mpc  [C];
  logic [W-1:0] mexp [C];
  int           merr [C];
`ifdef BSG_CHAN_LOOPBACK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < C; d++) begin
      mq[d].delete();
      mmap[d] = d;
      mpc[d]  = W'(d);
      mexp[d] = '0;
      merr[d] = 0;
    end
  endtask

  function automatic logic [C-1:0] model_ready(input logic rn, input logic pat);
    logic [C-1:0] r;
    r = '0;
    if (rn) begin
      if (pat) r = CheckEn ? '1 : '0;
      else begin
        for (int s = 0; s < C; s++) begin
          r[s] = 1'b1;
          for (int d = 0; d < C; d++)
            if (mmap[d] == s && mq[d].size() == E) r[s] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // One clock: drive, check combinational outputs against model, advance model.
  task automatic cycle(input logic rn, input logic [C-1:0] v, input logic [C*W-1:0] data,
                       input logic [C-1:0] yumi, input logic cv, input int dst, input int src,
                       input logic pat);
    logic [C-1:0]   ev, er, en;
    logic [C*W-1:0] ed;
    logic [C*16-1:0] ee;
    logic [W-1:0]   val [C];
    logic [W-1:0]   ds;
    @(negedge clk);
    ev = '0; ed = '0; ee = '0;
    for (int d = 0; d < C; d++) begin
      ev[d] = (mq[d].size() != 0);
      if (ev[d]) ed[d*W +: W] = mq[d][0];
      if (CheckEn) ee[d*16 +: 16] = 16'(merr[d]);
    end
    er = model_ready(rn, pat);
    reset_n = rn; v_i = v; data_i = data; yumi_i = yumi & ev;
    cfg_v = cv; cfg_dst = 2'(dst); cfg_src = 2'(src); pat_en = pat;
    #1;
    check("v_o", 64'(v_o), 64'(ev));
    check("data_o", 64'(data_o), 64'(ed));
    check("ready_o", 64'(ready_o), 64'(er));
    check("err_cnt", 64'(err_cnt_o), 64'(ee));
    @(posedge clk);
    if (!rn) model_reset();
    else begin
      for (int d = 0; d < C; d++) begin
        if (pat) begin
          en[d] = (mq[d].size() < E); val[d] = mpc[d];
        end else begin
          en[d] = v[mmap[d]] && er[mmap[d]]; val[d] = data[mmap[d]*W +: W];
        end
      end
      for (int d = 0; d < C; d++) if (yumi_i[d] && mq[d].size() > 0) void'(mq[d].pop_front());
      for (int d = 0; d < C; d++) if (en[d]) begin
        mq[d].push_back(val[d]);
        if (pat) mpc[d] = mpc[d] + 1'b1;
      end
      if (CheckEn && pat) begin
        for (int s = 0; s < C; s++) if (v[s]) begin
          ds = data[s*W +: W];
          if (ds != mexp[s] && merr[s] < 65535) merr[s]++;
          mexp[s] = ds + 1'b1;
        end
      end
      if (cv) mmap[dst] = src;
    end
  endtask

  task automatic idle(input logic pat);
    cycle(1'b1, '0, '0, '0, 1'b0, 0, 0, pat);
  endtask

  task automatic rnd(input int n, input logic pat, input int yumi_pct, input int cfg_pct);
    logic [C*W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b1, C'($urandom), d, C'($urandom_range(0, 99) < yumi_pct ? 4'hF : $urandom),
            ($urandom_range(0, 99) < cfg_pct), $urandom_range(0, C-1), $urandom_range(0, C-1),
            pat);
    end
  endtask

  initial begin
    reset_n = 1'b0; v_i = '0; data_i = '0; yumi_i = '0;
    cfg_v = 1'b0; cfg_dst = '0; cfg_src = '0; pat_en = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Single word on input 2 through identity map.
    cycle(1'b1, 4'b0100, 32'h005A_0000, '0, 1'b0, 0, 0, 1'b0);
    idle(1'b0);
    cycle(1'b1, '0, '0, 4'hF, 1'b0, 0, 0, 1'b0);

    // Fill output 0 past depth, then drain one.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0001, 32'(8'h30 + i), '0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 4'b0001, 32'h34, 4'b0001, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 4'b0001, 32'h35, '0, 1'b0, 0, 0, 1'b0);
    repeat (6) cycle(1'b1, '0, '0, 4'hF, 1'b0, 0, 0, 1'b0);

    // Fan-out of input 3 to outputs 0 and 1, with fill to test blocking.
    cycle(1'b1, '0, '0, '0, 1'b1, 1, 3, 1'b0);
    cycle(1'b1, 4'b1000, 32'h1100_0000, '0, 1'b1, 0, 3, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'b1000, 32'h1100_0000, '0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 4'b1000, 32'h2200_0000, 4'b0001, 1'b0, 0, 0, 1'b0);
    rnd(300, 1'b0, 30, 8);

    // Pattern mode streaming with full drain, long enough to wrap counters.
    rnd(300, 1'b1, 100, 0);
    rnd(100, 1'b1, 20, 5);

    // Reset with words queued, then check recovery.
    rnd(20, 1'b0, 0, 0);
    cycle(1'b0, '0, '0, '0, 1'b0, 0, 0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 4'hF, 32'hDDCC_BBAA, '0, 1'b0, 0, 0, 1'b0);
    idle(1'b0);

    // Checker sequence on input 0: one gap in 0,1,2,7,8.
    cycle(1'b0, '0, '0, '0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 4'b0001, 32'd0, '0, 1'b0, 0, 0, 1'b1);
    cycle(1'b1, 4'b0001, 32'd1, '0, 1'b0, 0, 0, 1'b1);
    cycle(1'b1, 4'b0001, 32'd2, '0, 1'b0, 0, 0, 1'b1);
    cycle(1'b1, 4'b0001, 32'd7, '0, 1'b0, 0, 0, 1'b1);
    cycle(1'b1, 4'b0001, 32'd8, '0, 1'b0, 0, 0, 1'b1);
    idle(1'b1);

    // Mixed modes with occasional resets.
    for (int k = 0; k < 12; k++) begin
      rnd(40, k[0], 40, 10);
      if (k % 4 == 3) cycle(1'b0, '0, '0, '0, 1'b0, 0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
